// File: rtl/rvvi_flow_ctrl.sv
// RVVI trace flow control: host-ack tracking, in-flight window
// and frame/gap pacing for the trace packetizer.
module rvvi_flow_ctrl #(
  parameter int          XLEN              = 64,
  parameter int          FRAME_COUNT_WIDTH = 16,
  parameter int          WINDOW            = 1024,
  parameter logic [31:0] INIT_DELAY        = 32'd16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         AckValid,
  input  logic [XLEN-1:0]              AckMinstr,
  input  logic [31:0]                  AckDelay,
  input  logic [FRAME_COUNT_WIDTH-1:0] AckFrameCount,
  input  logic [XLEN-1:0]              LocalMinstr,
  input  logic                         FrameReq,
  input  logic                         FrameSent,
  output logic                         FrameGrant,
  output logic                         WindowStall,
  output logic [XLEN-1:0]              AckedMinstr,
  output logic [31:0]                  CurrDelay,
  output logic [15:0]                  DropCount
);

  typedef enum logic [1:0] {
    IDLE,
    SENDING,
    GAP
  } state_t;

  localparam logic [XLEN-1:0] WinLim = XLEN'(WINDOW);
  localparam logic [FRAME_COUNT_WIDTH-1:0] FcOne =
    FRAME_COUNT_WIDTH'(1);

  state_t                         state;
  state_t                         state_nxt;
  logic [31:0]                    gapcnt;
  logic [FRAME_COUNT_WIDTH-1:0]   expectedfc;
  logic                           firstackseen;
  logic [XLEN-1:0]                inflight;
  logic                           fcmiss;

  // Modular distance so the window keeps working across counter wrap.
  assign inflight    = LocalMinstr - AckedMinstr;
  assign WindowStall = (inflight >= WinLim);
  assign fcmiss      = firstackseen && (AckFrameCount != expectedfc);

  // Host acknowledgement bookkeeping; the acked count only moves forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      AckedMinstr  <= '0;
      CurrDelay    <= INIT_DELAY;
      DropCount    <= '0;
      expectedfc   <= '0;
      firstackseen <= 1'b0;
    end else if (AckValid) begin
      if (AckMinstr > AckedMinstr)
        AckedMinstr <= AckMinstr;
      CurrDelay    <= AckDelay;
      firstackseen <= 1'b1;
      expectedfc   <= AckFrameCount + FcOne;
      if (fcmiss && (DropCount != 16'hFFFF))
        DropCount <= DropCount + 16'd1;
    end
  end

  // Gap counter is latched at frame end so later delay updates wait a gap.
  always_ff @(posedge clk) begin
    if (reset)
      gapcnt <= '0;
    else if ((state == SENDING) && FrameSent)
      gapcnt <= CurrDelay;
    else if (state == GAP)
      gapcnt <= gapcnt - 32'd1;
  end

  // Pacing state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and grant decode.
  always_comb begin
    state_nxt  = state;
    FrameGrant = 1'b0;
    unique case (state)
      IDLE: begin
        if (FrameReq && !WindowStall && !reset) begin
          FrameGrant = 1'b1;
          state_nxt  = SENDING;
        end
      end
      SENDING: begin
        if (FrameSent)
          state_nxt = (CurrDelay != 32'd0) ? GAP : IDLE;
      end
      GAP: begin
        if (gapcnt <= 32'd1)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rvvi_flow_ctrl.sv
// Directed vector bench for rvvi_flow_ctrl: per-cycle table
// plus short hand-written reset/grant sequences.
module tb_rvvi_flow_ctrl;

  logic        clk;
  logic        reset;
  logic        AckValid;
  logic [63:0] AckMinstr;
  logic [31:0] AckDelay;
  logic [15:0] AckFrameCount;
  logic [63:0] LocalMinstr;
  logic        FrameReq;
  logic        FrameSent;
  logic        FrameGrant;
  logic        WindowStall;
  logic [63:0] AckedMinstr;
  logic [31:0] CurrDelay;
  logic [15:0] DropCount;

  int nvec;
  int nbad;

  rvvi_flow_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .AckValid     (AckValid),
    .AckMinstr    (AckMinstr),
    .AckDelay     (AckDelay),
    .AckFrameCount(AckFrameCount),
    .LocalMinstr  (LocalMinstr),
    .FrameReq     (FrameReq),
    .FrameSent    (FrameSent),
    .FrameGrant   (FrameGrant),
    .WindowStall  (WindowStall),
    .AckedMinstr  (AckedMinstr),
    .CurrDelay    (CurrDelay),
    .DropCount    (DropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [63:0] am;
    logic [31:0] ad;
    logic [15:0] fc;
    logic [63:0] lm;
    logic        req;
    logic        sent;
    logic        eg;
    logic        es;
    logic [63:0] ea;
    logic [31:0] ed;
    logic [15:0] edc;
  } vec_t;

  vec_t tbl[$];

  // Inputs for one cycle, and the outputs expected just before its edge.
  task automatic v(input int rst, input int ack, input int am,
                   input int ad, input int fc, input int lm,
                   input int req, input int sent, input int eg,
                   input int es, input int ea, input int ed,
                   input int edc);
    vec_t t;
    t.rst  = rst[0];
    t.ack  = ack[0];
    t.am   = 64'(am);
    t.ad   = ad;
    t.fc   = fc[15:0];
    t.lm   = 64'(lm);
    t.req  = req[0];
    t.sent = sent[0];
    t.eg   = eg[0];
    t.es   = es[0];
    t.ea   = 64'(ea);
    t.ed   = ed;
    t.edc  = edc[15:0];
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic ok,
                     input string got, input string want);
    nvec++;
    if (!ok) begin
      nbad++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    nvec = 0;
    nbad = 0;
    reset = 1'b1;
    AckValid = 1'b0;
    AckMinstr = '0;
    AckDelay = '0;
    AckFrameCount = '0;
    LocalMinstr = '0;
    FrameReq = 1'b0;
    FrameSent = 1'b0;
    repeat (2) @(posedge clk);

    // window boundary, ack under stall, first ack value 7
    v(0,0,0,0,0,1023,0,0, 0,0,0,16,0);
    v(0,0,0,0,0,1024,0,0, 0,1,0,16,0);
    v(0,0,0,0,0,1024,1,0, 0,1,0,16,0);
    v(0,1,10,0,7,1024,0,0, 0,1,0,16,0);
    v(0,0,0,0,0,1024,0,0, 0,0,10,0,0);
    // zero delay: grant the cycle after FrameSent
    v(0,0,0,0,0,1024,1,0, 1,0,10,0,0);
    v(0,0,0,0,0,1024,0,1, 0,0,10,0,0);
    v(0,0,0,0,0,1024,1,0, 1,0,10,0,0);
    // delay 3: gap t+1..t+3, grant at t+4
    v(0,1,20,3,8,1024,0,0, 0,0,10,0,0);
    v(0,0,0,0,0,1024,1,1, 0,0,20,3,0);
    v(0,0,0,0,0,1024,1,0, 0,0,20,3,0);
    v(0,0,0,0,0,1024,1,0, 0,0,20,3,0);
    v(0,0,0,0,0,1024,1,1, 0,0,20,3,0);
    v(0,0,0,0,0,1024,1,0, 1,0,20,3,0);
    // monotonic ack
    v(0,1,500,5,9,1024,0,0, 0,0,20,3,0);
    v(0,1,400,6,10,1024,0,0, 0,0,500,5,0);
    // delay 10, then delay 2 arriving mid-gap
    v(0,1,600,10,11,1024,0,0, 0,0,500,6,0);
    v(0,0,0,0,0,1024,0,1, 0,0,600,10,0);
    v(0,0,0,0,0,1024,1,0, 0,0,600,10,0);
    v(0,1,601,2,12,1024,1,0, 0,0,600,10,0);
    for (int i = 0; i < 8; i++)
      v(0,0,0,0,0,1024,1,0, 0,0,601,2,0);
    v(0,0,0,0,0,1024,1,0, 1,0,601,2,0);
    v(0,0,0,0,0,1024,0,1, 0,0,601,2,0);
    v(0,0,0,0,0,1024,1,0, 0,0,601,2,0);
    v(0,0,0,0,0,1024,1,0, 0,0,601,2,0);
    v(0,0,0,0,0,1024,1,0, 1,0,601,2,0);
    // frame count FFFF (a miss) then 0000 (in order)
    v(0,1,0,4,'hFFFF,1024,0,0, 0,0,601,2,0);
    v(0,1,0,4,0,1024,0,0, 0,0,601,4,1);
    v(0,0,0,0,0,1024,0,0, 0,0,601,4,1);
    // reset in the middle of a gap
    v(0,0,0,0,0,1024,0,1, 0,0,601,4,1);
    v(0,0,0,0,0,1024,1,0, 0,0,601,4,1);
    v(1,0,0,0,0,1024,1,0, 0,0,601,4,1);
    v(0,0,0,0,0,1024,0,0, 0,1,0,16,0);
    v(0,0,0,0,0,100,1,0, 1,0,0,16,0);
    // frame counts 5,6,8,9 after reset
    v(0,1,50,0,5,100,0,0, 0,0,0,16,0);
    v(0,1,60,0,6,100,0,0, 0,0,50,0,0);
    v(0,1,70,0,8,100,0,0, 0,0,60,0,0);
    v(0,1,80,0,9,100,0,0, 0,0,70,0,1);
    v(0,0,0,0,0,100,0,0, 0,0,80,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      AckValid = tbl[i].ack;
      AckMinstr = tbl[i].am;
      AckDelay = tbl[i].ad;
      AckFrameCount = tbl[i].fc;
      LocalMinstr = tbl[i].lm;
      FrameReq = tbl[i].req;
      FrameSent = tbl[i].sent;
      #1;
      chk($sformatf("vec%0d", i),
          (FrameGrant === tbl[i].eg) &&
          (WindowStall === tbl[i].es) &&
          (AckedMinstr === tbl[i].ea) &&
          (CurrDelay === tbl[i].ed) &&
          (DropCount === tbl[i].edc),
          $sformatf("g=%0b s=%0b a=%0d d=%0d dc=%0d", FrameGrant,
                    WindowStall, AckedMinstr, CurrDelay, DropCount),
          $sformatf("g=%0b s=%0b a=%0d d=%0d dc=%0d", tbl[i].eg,
                    tbl[i].es, tbl[i].ea, tbl[i].ed, tbl[i].edc));
    end

    // grant is held off while reset is asserted, even in IDLE
    @(negedge clk);
    reset = 1'b1;
    AckValid = 1'b0;
    FrameSent = 1'b0;
    FrameReq = 1'b0;
    LocalMinstr = '0;
    @(negedge clk);
    FrameReq = 1'b1;
    #1;
    chk("rst_gate", FrameGrant === 1'b0,
        $sformatf("g=%0b", FrameGrant), "g=0");

    // first grant after release, bounded wait
    @(negedge clk);
    reset = 1'b0;
    begin
      int k;
      k = 0;
      #1;
      while (FrameGrant !== 1'b1 && k < 4) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk("grant_after_rst", (FrameGrant === 1'b1) && (k == 0),
          $sformatf("g=%0b wait=%0d", FrameGrant, k), "g=1 wait=0");
    end

    // reset while SENDING aborts to IDLE
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_in_send", FrameGrant === 1'b0,
        $sformatf("g=%0b", FrameGrant), "g=0");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_after_abort",
        (FrameGrant === 1'b1) && (CurrDelay === 32'd16),
        $sformatf("g=%0b d=%0d", FrameGrant, CurrDelay), "g=1 d=16");

    @(negedge clk);
    FrameReq = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
